// File: rtl/vec_ctrl_pkg.sv
// Shared opcode map, class/state enums and the opcode classifier used by the
// decoder and the vector execute sequencer.
package vec_ctrl_pkg;

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_B    = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;

  typedef enum logic [1:0] {CLS_MULTI, CLS_LANE, CLS_SCALAR} op_class_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE} seq_state_t;

  // Unlisted opcodes fall into the scalar class and never touch the datapath.
  function automatic op_class_t op_class(input logic [3:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_MUL, OP_DIV:                                        cls = CLS_MULTI;
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI:        cls = CLS_LANE;
      OP_B, OP_BEQ:                                          cls = CLS_SCALAR;
      default:                                               cls = CLS_SCALAR;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vector_op_sequencer_if.sv
// Issue / datapath / MUL-DIV handshake bundle between the decoder side
// (master) and the vector execute sequencer (slave).
interface vector_op_sequencer_if #(
  parameter int LANES = 4
);
  localparam int LW = $clog2(LANES);

  logic          issue_valid;
  logic [3:0]    issue_opcode;
  logic [LW:0]   issue_vl;
  logic          issue_ready;
  logic          flush;
  logic [LW-1:0] lane_idx;
  logic          lane_en;
  logic          unit_start;
  logic          unit_done;
  logic          stall;
  logic          op_done;
  logic          error;

  modport master (
    output issue_valid, issue_opcode, issue_vl, flush, unit_done,
    input  issue_ready, lane_idx, lane_en, unit_start, stall, op_done, error
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_vl, flush, unit_done,
    output issue_ready, lane_idx, lane_en, unit_start, stall, op_done, error
  );

endinterface

// File: rtl/vector_op_sequencer_unit_watchdog.sv
// Counts WAIT cycles spent on the MUL/DIV unit; expired flags the cycle that
// is the TIMEOUT-th consecutive wait without a result.
module unit_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1'b1);

  logic [CW-1:0] count_r;

  // Wait-cycle counter, saturating at the expiry point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/vector_op_sequencer.sv
// Steps one decoded vector instruction lane by lane over the shared datapath,
// handshaking with the iterative MUL/DIV unit and stalling the front end.
module vector_op_sequencer
  import vec_ctrl_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_op_sequencer_if.slave  bus
);
  localparam int            LW       = $clog2(LANES);
  localparam logic [LW-1:0] LANE_ONE = LW'(1'b1);
  localparam logic [LW:0]   VL_ONE   = (LW + 1)'(1'b1);

  seq_state_t    state_r, state_nx;
  op_class_t     cls_r, cls_nx;
  logic [LW:0]   vl_r, vl_nx;
  logic [LW-1:0] lane_r, lane_nx;
  logic          error_r, error_nx;
  logic          lane_en_r, unit_start_r, op_done_r, stall_r, issue_ready_r;
  logic          last_lane_s, wd_expired_s;

  assign last_lane_s = ({1'b0, lane_r} == (vl_r - VL_ONE));

  unit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_r == S_EXEC),
    .enable  (state_r == S_WAIT),
    .expired (wd_expired_s)
  );

  // Next-state, lane and error decisions.
  always_comb begin
    state_nx = state_r;
    cls_nx   = cls_r;
    vl_nx    = vl_r;
    lane_nx  = lane_r;
    error_nx = error_r;
    if ((state_r != S_IDLE) && bus.flush) begin
      state_nx = S_IDLE;
      lane_nx  = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.issue_valid) begin
            cls_nx   = op_class(bus.issue_opcode);
            vl_nx    = bus.issue_vl;
            lane_nx  = '0;
            error_nx = 1'b0;
            if ((cls_nx == CLS_SCALAR) || (bus.issue_vl == '0)) begin
              state_nx = S_DONE;
            end else begin
              state_nx = S_EXEC;
            end
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_EXEC: begin
          if (cls_r == CLS_MULTI) begin
            state_nx = S_WAIT;
          end else if (last_lane_s) begin
            state_nx = S_DONE;
          end else begin
            lane_nx = lane_r + LANE_ONE;
          end
        end
        S_WAIT: begin
          // A result arriving on the expiry cycle still counts as success.
          if (bus.unit_done) begin
            if (last_lane_s) begin
              state_nx = S_DONE;
            end else begin
              lane_nx  = lane_r + LANE_ONE;
              state_nx = S_EXEC;
            end
          end else if (wd_expired_s) begin
            error_nx = 1'b1;
            state_nx = S_DONE;
          end else begin
            state_nx = S_WAIT;
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State register with outputs registered as decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cls_r         <= CLS_SCALAR;
      vl_r          <= '0;
      lane_r        <= '0;
      error_r       <= 1'b0;
      lane_en_r     <= 1'b0;
      unit_start_r  <= 1'b0;
      op_done_r     <= 1'b0;
      stall_r       <= 1'b0;
      issue_ready_r <= 1'b1;
    end else begin
      state_r       <= state_nx;
      cls_r         <= cls_nx;
      vl_r          <= vl_nx;
      lane_r        <= lane_nx;
      error_r       <= error_nx;
      lane_en_r     <= (state_nx == S_EXEC) || (state_nx == S_WAIT);
      unit_start_r  <= (state_nx == S_EXEC) && (cls_nx == CLS_MULTI);
      op_done_r     <= (state_nx == S_DONE);
      stall_r       <= (state_nx != S_IDLE);
      issue_ready_r <= (state_nx == S_IDLE);
    end
  end

  assign bus.issue_ready = issue_ready_r;
  assign bus.lane_idx    = lane_r;
  assign bus.lane_en     = lane_en_r;
  assign bus.unit_start  = unit_start_r;
  assign bus.stall       = stall_r;
  assign bus.op_done     = op_done_r;
  assign bus.error       = error_r;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Randomised bench for vector_op_sequencer: a per-instruction cycle trace is
// predicted from the opcode class, vl and the unit_done schedule, then compared.
module tb_vector_op_sequencer;
  import vec_ctrl_pkg::*;

  localparam int LANES   = 4;
  localparam int TIMEOUT = 64;
  localparam int MAXT    = 600;

  logic clk;
  logic rst;

  vector_op_sequencer_if #(.LANES(LANES)) bus ();

  vector_op_sequencer #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int exp_err = 0;

  // Plan for the next instruction: WAIT cycle (1-based) on which unit_done
  // arrives for each lane (0 = never), flush cycle (0 = none), EXEC noise.
  int done_at [LANES];
  int flush_at;
  int exec_noise;

  // Expected trace, entries 1..tn are the cycles after the accept edge.
  int tn;
  int e_en [MAXT];
  int e_idx[MAXT];
  int e_st [MAXT];
  int e_dn [MAXT];
  int e_er [MAXT];
  int d_ud [MAXT];

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_idle(input int err);
    check_eq("idle_ready", int'(bus.issue_ready), 1);
    check_eq("idle_stall", int'(bus.stall), 0);
    check_eq("idle_lane_en", int'(bus.lane_en), 0);
    check_eq("idle_start", int'(bus.unit_start), 0);
    check_eq("idle_op_done", int'(bus.op_done), 0);
    check_eq("idle_error", int'(bus.error), err);
  endtask

  function automatic void add_entry(int en, int idx, int st, int dn, int er, int ud);
    tn++;
    e_en[tn] = en; e_idx[tn] = idx; e_st[tn] = st;
    e_dn[tn] = dn; e_er[tn] = er; d_ud[tn] = ud;
  endfunction

  function automatic int coin();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic void build_trace(input logic [3:0] op, input int vl);
    bit multi, lane_cls;
    int timed;
    bit hit;
    tn = 0;
    multi    = (op == OP_MUL) || (op == OP_DIV);
    lane_cls = (op >= OP_LD) && (op <= OP_SUBI);
    timed    = 0;
    if ((!multi && !lane_cls) || vl == 0) begin
      add_entry(0, 0, 0, 1, 0, coin());
    end else if (lane_cls) begin
      for (int l = 0; l < vl; l++) add_entry(1, l, 0, 0, 0, coin());
      add_entry(0, 0, 0, 1, 0, coin());
    end else begin
      for (int l = 0; l < vl && timed == 0; l++) begin
        add_entry(1, l, 1, 0, 0, exec_noise != 0 ? coin() : 0);
        for (int w = 1; w <= TIMEOUT; w++) begin
          hit = (done_at[l] == w);
          add_entry(1, l, 0, 0, 0, int'(hit));
          if (hit) break;
          if (w == TIMEOUT) timed = 1;
        end
      end
      add_entry(0, 0, 0, 1, timed, coin());
    end
  endfunction

  task automatic set_plan(input int d0, input int d1, input int d2, input int d3,
                          input int f, input int noise);
    done_at[0] = d0; done_at[1] = d1; done_at[2] = d2; done_at[3] = d3;
    flush_at = f;
    exec_noise = noise;
  endtask

  task automatic run_op(input logic [3:0] op, input int vl, input int gap);
    int len;
    bit flushed;
    build_trace(op, vl);
    flushed = (flush_at > 0) && (flush_at < tn);
    len = flushed ? flush_at : tn;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check_idle(exp_err);
      bus.issue_valid = 1'b0;
      bus.flush       = 1'($urandom_range(0, 1));
      bus.unit_done   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    check_idle(exp_err);
    bus.issue_valid  = 1'b1;
    bus.issue_opcode = op;
    bus.issue_vl     = 3'(vl);
    bus.flush        = 1'($urandom_range(0, 1));
    bus.unit_done    = 1'($urandom_range(0, 1));
    for (int t = 1; t <= len; t++) begin
      @(posedge clk); #1;
      check_eq("stall", int'(bus.stall), 1);
      check_eq("issue_ready", int'(bus.issue_ready), 0);
      check_eq("lane_en", int'(bus.lane_en), e_en[t]);
      if (e_en[t] != 0) check_eq("lane_idx", int'(bus.lane_idx), e_idx[t]);
      check_eq("unit_start", int'(bus.unit_start), e_st[t]);
      check_eq("op_done", int'(bus.op_done), e_dn[t]);
      check_eq("error", int'(bus.error), e_er[t]);
      bus.issue_valid  = 1'($urandom_range(0, 1));
      bus.issue_opcode = 4'($urandom);
      bus.issue_vl     = 3'($urandom_range(0, LANES));
      bus.flush        = (flushed && t == len) ? 1'b1 : 1'b0;
      bus.unit_done    = 1'(d_ud[t]);
    end
    exp_err = flushed ? 0 : e_er[tn];
  endtask

  initial begin
    rst = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.issue_opcode = 4'd0;
    bus.issue_vl     = 3'd0;
    bus.flush        = 1'b0;
    bus.unit_done    = 1'b0;
    #2;
    check_idle(0);
    check_eq("rst_lane_idx", int'(bus.lane_idx), 0);
    @(posedge clk); #1;
    check_idle(0);
    rst = 1'b0;

    set_plan(0, 0, 0, 0, 0, 0);
    run_op(OP_ADD, 4, 0);
    set_plan(3, 3, 0, 0, 0, 0);
    run_op(OP_MUL, 2, 1);
    set_plan(0, 0, 0, 0, 0, 0);
    run_op(OP_DIV, 1, 0);
    run_op(OP_BEQ, 3, 0);
    run_op(OP_ADD, 0, 1);
    set_plan(0, 0, 0, 0, 3, 0);
    run_op(OP_SUB, 4, 0);
    set_plan(TIMEOUT, 2, 0, 0, 0, 1);
    run_op(OP_MUL, 2, 0);
    set_plan(1, 1, 1, 1, 0, 1);
    run_op(OP_DIV, 4, 0);

    // Reset asserted mid-WAIT must restore reset values without a clock edge.
    @(posedge clk); #1;
    check_idle(exp_err);
    bus.issue_valid = 1'b1; bus.issue_opcode = OP_MUL; bus.issue_vl = 3'd2;
    bus.flush = 1'b0; bus.unit_done = 1'b0;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    check_eq("mid_start", int'(bus.unit_start), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("mid_wait_en", int'(bus.lane_en), 1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_idle(0);
    check_eq("mid_rst_lane_idx", int'(bus.lane_idx), 0);
    @(posedge clk); #1;
    check_idle(0);
    rst = 1'b0;
    exp_err = 0;

    for (int n = 0; n < 40; n++) begin
      int r;
      for (int l = 0; l < LANES; l++) begin
        r = int'($urandom_range(0, 19));
        if (r == 0)      done_at[l] = 0;
        else if (r == 1) done_at[l] = TIMEOUT;
        else             done_at[l] = int'($urandom_range(1, 4));
      end
      flush_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
      exec_noise = coin();
      run_op(4'($urandom), int'($urandom_range(0, LANES)), int'($urandom_range(0, 2)));
    end

    @(posedge clk); #1;
    check_idle(exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
